// File: rtl/seq_scan_pkg.sv
// Shared types for the serial pattern scanner: FSM state encoding and count width helper.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..w inclusive
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_match.sv
// Bit-history shift register with saturating valid-bit counter and combinational hit detect.
module seq_match #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit_c
);

  localparam int unsigned HW = PAT_W - 1;
  localparam int unsigned VW = $clog2(PAT_W);

  logic [HW-1:0] hist;
  logic [VW-1:0] vcnt;

  // Clear wins over shift; the valid count stops once a full window of history exists
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      vcnt <= '0;
    end else if (clear) begin
      hist <= '0;
      vcnt <= '0;
    end else if (shift) begin
      hist <= HW'({hist, bit_in});
      if (vcnt != VW'(HW)) vcnt <= vcnt + VW'(1);
    end
  end

  assign hit_c = ({hist, bit_in} == pattern) && (vcnt == VW'(HW));

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial overlapping pattern counter over WORD_W-bit words, MSB first.
// Define SEQ_SCAN_CARRY_EN to keep bit history across words (matches may straddle words).
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter  int unsigned WORD_W = 16,
  parameter  int unsigned PAT_W  = 4,
  localparam int unsigned CNT_W  = cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count
);

  localparam int unsigned BW = $clog2(WORD_W);

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [PAT_W-1:0]  pat_q;
  logic [BW-1:0]     bit_cnt;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_next;
  logic              accept;
  logic              clear;
  logic              shift;
  logic              last;
  logic              hit_c;

  assign word_ready = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign accept     = word_valid && word_ready;
  assign shift      = (state == SHIFT);
  assign last       = (bit_cnt == BW'(WORD_W - 1));
  assign acc_next   = (hit_c && (acc != CNT_W'(WORD_W))) ? acc + CNT_W'(1) : acc;

  // History may only be cleared while idle; flush during a scan is ignored
`ifdef SEQ_SCAN_CARRY_EN
  assign clear = (state == IDLE) && flush;
`else
  assign clear = (state == IDLE) && (flush || accept);
`endif

  seq_match #(.PAT_W(PAT_W)) u_match (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .shift   (shift),
    .bit_in  (word_q[WORD_W-1]),
    .pattern (pat_q),
    .hit_c   (hit_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_q      <= '0;
      pat_q       <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      match_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            word_q  <= word_data;
            pat_q   <= cfg_pattern;
            bit_cnt <= '0;
            acc     <= '0;
          end
        end
        SHIFT: begin
          word_q  <= {word_q[WORD_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BW'(1);
          acc     <= acc_next;
          if (last) begin
            state       <= DONE;
            match_count <= acc_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: queue-based reference model plus directed vectors.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 16;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 5;
`ifdef SEQ_SCAN_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              word_valid = 1'b0;
  logic              flush = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  match_count;

  int n_cmp = 0;
  int n_bad = 0;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_pattern (cfg_pattern),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model: last PAT_W bits seen, busy countdown, pending and visible count
  bit hist[$];
  int mcyc   = 0;
  int pend   = 0;
  int exp_mc = 0;

  function automatic int scan(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p);
    int n = 0;
    bit m;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      hist.push_back(w[i]);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      if (hist.size() == PAT_W) begin
        m = 1'b1;
        for (int k = 0; k < PAT_W; k++) if (hist[k] != p[PAT_W-1-k]) m = 1'b0;
        if (m) n++;
      end
    end
    return n;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      hist.delete();
      mcyc   = 0;
      exp_mc = 0;
    end else if (mcyc > 0) begin
      mcyc--;
      if (mcyc == 1) exp_mc = pend;
    end else begin
      if (flush) hist.delete();
      if (word_valid) begin
        if (!CARRY) hist.delete();
        pend = scan(word_data, cfg_pattern);
        mcyc = WORD_W + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("word_ready", word_ready, int'(mcyc == 0 && !rst));
    chk("busy", busy, int'(mcyc > 0));
    chk("done", done, int'(mcyc == 1));
    chk("match_count", match_count, exp_mc);
  end

  // Observed DUT acceptances, sampled mid-low-phase once inputs have settled
  int ncyc = 0;
  int dut_acc[$];
  initial forever begin
    @(negedge clk);
    #3;
    ncyc++;
    if (word_valid && word_ready) dut_acc.push_back(ncyc);
  end

  task automatic send(input logic [PAT_W-1:0] p, input logic [WORD_W-1:0] w,
                      input logic fl, input string name, input int exp_cnt);
    int lat = 1;
    @(negedge clk);
    cfg_pattern = p;
    word_data   = w;
    word_valid  = 1'b1;
    flush       = fl;
    @(negedge clk);
    word_valid  = 1'b0;
    flush       = 1'b0;
    cfg_pattern = ~p;
    word_data   = ~w;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, lat, 17);
    chk({name, " count"}, match_count, exp_cnt);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst word_ready", word_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst match_count", match_count, 0);
    #1 rst = 1'b0;
    #1 chk("ready after rst", word_ready, 1);

    send(4'b0110, 16'h6666, 1'b0, "p0110", 4);
    send(4'b0000, 16'h0000, 1'b0, "p0000", 13);
    send(4'b1111, 16'hFFFF, 1'b0, "p1111", 13);

    // Reset at shift edge 8 drops the word in flight
    @(negedge clk);
    cfg_pattern = 4'b0110;
    word_data   = 16'h6666;
    word_valid  = 1'b1;
    @(negedge clk);
    word_valid  = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst word_ready", word_ready, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst match_count", match_count, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("ready after midrst", word_ready, 1);
    send(4'b0110, 16'h6666, 1'b0, "after rst", 4);

    send(4'b1111, 16'h0003, 1'b0, "carry A", 0);
    send(4'b1111, 16'hC000, 1'b0, "carry B", CARRY ? 1 : 0);
    send(4'b1111, 16'h0003, 1'b0, "flush A", 0);
    send(4'b1111, 16'hC000, 1'b1, "flush B", 0);

    // Back-to-back words with word_valid held high
    dut_acc.delete();
    @(negedge clk);
    cfg_pattern = 4'b0110;
    word_data   = 16'h6666;
    word_valid  = 1'b1;
    @(negedge clk);
    word_data   = 16'h0660;
    chk("ready low while busy", word_ready, 0);
    begin
      int t = 0;
      while (dut_acc.size() < 2 && t < 60) begin
        @(negedge clk);
        t++;
      end
    end
    word_valid = 1'b0;
    chk("second accept seen", dut_acc.size(), 2);
    if (dut_acc.size() == 2) chk("accept spacing", dut_acc[1] - dut_acc[0], WORD_W + 2);
    begin
      int t = 0;
      while (!done && t < 40) begin
        @(negedge clk);
        t++;
      end
    end
    chk("b2b second count", match_count, 2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL expose these parameters: WORD_W, default 16, bits per input word; PAT_W, default 4, pattern length in bits.
REQ-002 The block SHALL expose these ports: clk  in  1  single clock, all state on rising edge.
REQ-003 The block SHALL expose: rst  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL expose: cfg_pattern  in  PAT_W  pattern to detect, MSB compared first.
REQ-005 The block SHALL expose: word_valid  in  1  word_data offered.
REQ-006 The block SHALL expose: word_data  in  WORD_W  word to scan, serialized MSB first.
REQ-007 The block SHALL expose: word_ready  out  1  controller accepts a word this cycle.
REQ-008 The block SHALL expose: flush  in  1  clear bit history.
REQ-009 The block SHALL expose: busy  out  1  a word is being scanned.
REQ-010 The block SHALL expose: done  out  1  one-cycle pulse, match_count valid.
REQ-011 The block SHALL expose: match_count  out  CNT_W  overlapping matches in the last word, where CNT_W = clog2(WORD_W+1).

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-013 word_ready SHALL be 1 only in IDLE with rst low.
REQ-014 Acceptance SHALL occur on an edge with word_valid&&word_ready; at that edge the FSM enters SHIFT and latches word_data and cfg_pattern, bit counter = 0, count accumulator = 0.
REQ-015 In SHIFT, one bit (MSB first) SHALL be shifted into history per edge for WORD_W edges; the FSM then enters DONE.
REQ-016 A hit SHALL be {history[PAT_W-2:0], current_bit} == latched pattern AND at least PAT_W-1 valid history bits; each hit increments the accumulator on that edge.
REQ-017 Matches SHALL overlap.
REQ-018 The accumulator SHALL NOT wrap (maximum WORD_W).
REQ-019 DONE SHALL last exactly one cycle with done=1 and match_count = final accumulator; the FSM then returns to IDLE.
REQ-020 Latency SHALL be: done high in the cycle after shift edge WORD_W.
REQ-021 Throughput SHALL be one word per WORD_W+2 cycles.
REQ-022 match_count SHALL hold its value until the next DONE.
REQ-023 busy SHALL be 1 in SHIFT and DONE.
REQ-024 flush in IDLE SHALL clear the history and the valid-bit count; flush in SHIFT/DONE SHALL be ignored.
REQ-025 If flush and an accepted word occur on the same edge, the history SHALL be cleared first and scanning starts from empty history.
REQ-026 cfg_pattern changes after acceptance SHALL NOT affect the word in flight.

Reset
REQ-027 While rst is high, the block SHALL immediately force: state=IDLE, word_ready=0, busy=0, done=0, match_count=0, history and valid count cleared.
REQ-028 A reset mid-SHIFT SHALL discard the word in flight with no done pulse.
REQ-029 After rst falls, word_ready SHALL be 1 from the first cycle.

Configuration
REQ-030 With SEQ_SCAN_CARRY_EN defined, history SHALL persist across words (cleared only by rst or flush), so matches may straddle word boundaries.
REQ-031 Without SEQ_SCAN_CARRY_EN, history SHALL be cleared at every acceptance edge.

Structure
REQ-032 Package seq_scan_pkg SHALL hold the FSM state enum and the CNT_W width function.
REQ-033 Sub-module seq_match SHALL hold the history shift register, the saturating valid-bit counter, clear/shift controls and the combinational hit output; seq_scan_ctrl holds the FSM, word register, bit counter and accumulator.

Verification
REQ-034 Bench SHALL cover: pattern 0110, word 16'h6666, no carry -> done 17 cycles after the acceptance edge, match_count=4.
REQ-035 Bench SHALL cover: pattern 0000, word 16'h0000 -> match_count=13; then pattern 1111, word 16'hFFFF -> 13.
REQ-036 Bench SHALL cover: pattern 1111, words 16'h0003 then 16'hC000 -> counts 0,0 without SEQ_SCAN_CARRY_EN; 0,1 with it.
REQ-037 Bench SHALL cover: carry build, same sequence with flush asserted on the second word's acceptance edge -> counts 0,0.
REQ-038 Bench SHALL cover: rst pulsed at shift edge 8 of 16'h6666 -> outputs 0 at once, no done; next 16'h6666 -> 4.
REQ-039 Bench SHALL cover: word_valid held high with two words -> word_ready low while busy; second acceptance occurs exactly WORD_W+2 cycles after the first.
